// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the core and muldiv_unit.
// The core drives the master side and the unit drives the slave side.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Funct, OpA, OpB,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, Funct, OpA, OpB,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 mul/div sequencer with HI/LO registers.
// Signed ops run on magnitudes; signs are fixed up in the FIX state.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]        r_count;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_orig;
  logic [2*WIDTH-1:0]   r_p;
  logic                 r_is_div;
  logic                 r_sgn_a;
  logic                 r_sgn_q;
  logic                 r_bz;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  logic                 w_idle;
  logic                 w_mul;
  logic                 w_div;
  logic                 w_signed;
  logic                 w_go;
  logic                 w_mthi;
  logic                 w_mtlo;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_msum;
  logic [2*WIDTH-1:0]   w_mstep;
  logic [WIDTH:0]       w_rsh;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_dstep;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_q;
  logic [WIDTH-1:0]     w_r;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  assign w_idle   = (r_state == S_IDLE);
  assign w_mul    = (bus.Funct == F_MULT) || (bus.Funct == F_MULTU);
  assign w_div    = (bus.Funct == F_DIV)  || (bus.Funct == F_DIVU);
  assign w_signed = (bus.Funct == F_MULT) || (bus.Funct == F_DIV);
  assign w_go     = w_idle && bus.Start && (w_mul || w_div);
  assign w_mthi   = w_idle && bus.Start && (bus.Funct == F_MTHI);
  assign w_mtlo   = w_idle && bus.Start && (bus.Funct == F_MTLO);

  assign w_a_neg  = w_signed && bus.OpA[WIDTH-1];
  assign w_b_neg  = w_signed && bus.OpB[WIDTH-1];
  assign w_abs_a  = w_a_neg ? (~bus.OpA + 1'b1) : bus.OpA;
  assign w_abs_b  = w_b_neg ? (~bus.OpB + 1'b1) : bus.OpB;

  // Multiply step: conditionally add multiplicand to the high half,
  // then shift the whole product/multiplier register right.
  assign w_msum   = {1'b0, r_p[2*WIDTH-1:WIDTH]}
                  + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_mstep  = {w_msum, r_p[WIDTH-1:1]};

  // Divide step: shift remainder:dividend left, subtract divisor,
  // keep the difference only when it did not go negative.
  assign w_rsh    = r_p[2*WIDTH-1:WIDTH-1];
  assign w_diff   = w_rsh - {1'b0, r_m};
  assign w_dstep  = w_diff[WIDTH]
                  ? {r_p[2*WIDTH-2:0], 1'b0}
                  : {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};

  assign w_prod   = r_sgn_q ? (~r_p + 1'b1) : r_p;
  assign w_q      = r_p[WIDTH-1:0];
  assign w_r      = r_p[2*WIDTH-1:WIDTH];

  // Select the final HI/LO values written in FIX.
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_bz) begin
        w_res_hi = r_orig;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_sgn_a ? (~w_r + 1'b1) : w_r;
        w_res_lo = r_sgn_q ? (~w_q + 1'b1) : w_q;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_go) w_next = S_RUN;
      S_RUN:  if (r_count == LAST) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, result write and MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_m      <= '0;
      r_orig   <= '0;
      r_p      <= '0;
      r_is_div <= 1'b0;
      r_sgn_a  <= 1'b0;
      r_sgn_q  <= 1'b0;
      r_bz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_count  <= '0;
            r_is_div <= w_div;
            r_sgn_a  <= w_a_neg;
            r_sgn_q  <= w_a_neg ^ w_b_neg;
            r_bz     <= (bus.OpB == '0);
            r_orig   <= bus.OpA;
            r_m      <= w_div ? w_abs_b : w_abs_a;
            r_p      <= {{WIDTH{1'b0}}, w_div ? w_abs_a : w_abs_b};
          end else if (w_mthi) begin
            r_hi <= bus.OpA;
          end else if (w_mtlo) begin
            r_lo <= bus.OpA;
          end
        end
        S_RUN: begin
          r_p     <= r_is_div ? w_dstep : w_mstep;
          r_count <= r_count + 1'b1;
        end
        S_FIX: begin
          r_hi   <= w_res_hi;
          r_lo   <= w_res_lo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy = (r_state != S_IDLE);
  assign bus.Done = r_done;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed checks of muldiv_unit against
// an arithmetic reference model of HI/LO, Busy and Done.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [5:0] fl [6];
  initial begin
    fl[0] = F_MULT;  fl[1] = F_MULTU;
    fl[2] = F_DIV;   fl[3] = F_DIVU;
    fl[4] = F_MTHI;  fl[5] = F_MTLO;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [5:0] f,
                                 input logic [31:0] a, b,
                                 output logic [31:0] h, l);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    p = '0;
    h = '0;
    l = '0;
    case (f)
      F_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        h = p[63:32]; l = p[31:0];
      end
      F_MULT: begin
        p = longint'(sa) * longint'(sb);
        h = p[63:32]; l = p[31:0];
      end
      F_DIVU: begin
        if (b == 0) begin h = a; l = '1; end
        else begin l = a / b; h = a % b; end
      end
      F_DIV: begin
        if (b == 0) begin h = a; l = '1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          l = 32'h80000000; h = 0;
        end else begin l = sa / sb; h = sa % sb; end
      end
      default: ;
    endcase
  endfunction

  // Reference model: latency counter plus pending architectural result.
  int          m_left = 0;
  bit          m_valid = 0;
  bit          m_done = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  int          done_cnt = 0;

  always @(posedge clk) begin
    m_done = 0;
    if (!rst_n) begin
      m_left = 0; m_hi = 0; m_lo = 0; m_valid = 1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1;
      end
    end else if (bus.Start) begin
      case (bus.Funct)
        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
          ref_op(bus.Funct, bus.OpA, bus.OpB, p_hi, p_lo);
          m_left = W + 1;
        end
        F_MTHI: m_hi = bus.OpA;
        F_MTLO: m_lo = bus.OpA;
        default: ;
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(bus.Busy), 32'(m_left > 0));
      chk("done", 32'(bus.Done), 32'(m_done));
      chk("hi", bus.HI, m_hi);
      chk("lo", bus.LO, m_lo);
      if (bus.Done) done_cnt++;
    end
  end

  task automatic drive_idle();
    bus.Start = 0;
    bus.Funct = fl[$urandom_range(0, 5)];
    bus.OpA = $urandom;
    bus.OpB = $urandom;
  endtask

  // Issue one mul/div, wait for Done, check latency and optionally literals.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, b,
                       input bit lit, input logic [31:0] eh, el,
                       input bit noise);
    int n;
    int bc;
    @(negedge clk);
    bus.Start = 1; bus.Funct = f; bus.OpA = a; bus.OpB = b;
    n = 0; bc = 0;
    do begin
      @(negedge clk);
      drive_idle();
      if (bus.Busy) begin
        bc++;
        if (noise) bus.Start = 1'($urandom_range(0, 1));
      end
      n++;
    end while (!bus.Done && n < 100);
    chk("done_seen", 32'(bus.Done), 32'd1);
    chk("busy_cycles", bc, W + 1);
    if (lit) begin
      chk("lit_hi", bus.HI, eh);
      chk("lit_lo", bus.LO, el);
    end
  endtask

  function automatic logic [31:0] pick(input int k);
    case (k)
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dc;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_hi", bus.HI, 0);
    chk("rst_lo", bus.LO, 0);
    rst_n = 1;

    do_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,
          32'hFFFFFFFE, 32'h00000001, 0);
    @(negedge clk);
    chk("done_single", 32'(bus.Done), 0);
    do_op(F_MULT, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    do_op(F_MULT, 32'd0, 32'h80000000, 1, 32'h0, 32'h0, 0);
    do_op(F_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    do_op(F_DIVU, 32'd7, 32'd2, 1, 32'd1, 32'd3, 0);
    do_op(F_DIVU, 32'd7, 32'd0, 1, 32'd7, 32'hFFFFFFFF, 0);
    do_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, 0);
    do_op(F_DIV, 32'hFFFFFFF9, 32'd0, 1, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);

    // Start during RUN is ignored.
    @(negedge clk);
    bus.Start = 1; bus.Funct = F_MULTU;
    bus.OpA = 32'hFFFFFFFF; bus.OpB = 32'd3;
    @(negedge clk); drive_idle();
    repeat (4) @(negedge clk);
    bus.Start = 1; bus.Funct = F_DIV; bus.OpA = 32'd9; bus.OpB = 32'd4;
    @(negedge clk); drive_idle();
    dc = 0;
    while (!bus.Done && dc < 100) begin @(negedge clk); dc++; end
    chk("ign_done", 32'(bus.Done), 1);
    chk("ign_hi", bus.HI, 32'd2);
    chk("ign_lo", bus.LO, 32'hFFFFFFFD);

    // Reset mid-operation discards the result.
    @(negedge clk);
    bus.Start = 1; bus.Funct = F_MULT;
    bus.OpA = 32'h1234; bus.OpB = 32'h5678;
    @(negedge clk); drive_idle();
    repeat (9) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mrst_busy", 32'(bus.Busy), 0);
    chk("mrst_hi", bus.HI, 0);
    chk("mrst_lo", bus.LO, 0);
    dc = done_cnt;
    repeat (45) @(negedge clk);
    chk("mrst_nodone", done_cnt - dc, 0);

    // MTHI / MTLO.
    bus.Start = 1; bus.Funct = F_MTHI; bus.OpA = 32'h12345678;
    @(negedge clk);
    drive_idle();
    chk("mthi_hi", bus.HI, 32'h12345678);
    chk("mthi_busy", 32'(bus.Busy), 0);
    bus.Start = 1; bus.Funct = F_MTLO; bus.OpA = 32'h9ABCDEF0;
    @(negedge clk);
    drive_idle();
    chk("mtlo_lo", bus.LO, 32'h9ABCDEF0);
    chk("mtlo_hi", bus.HI, 32'h12345678);
    chk("mtlo_done", 32'(bus.Done), 0);

    // Random mix against the model.
    for (int i = 0; i < 60; i++) begin
      int k;
      logic [31:0] a, b;
      k = $urandom_range(0, 6);
      a = pick($urandom_range(0, 7));
      b = pick($urandom_range(0, 7));
      if (k < 4) begin
        do_op(fl[k], a, b, 0, 0, 0, 1);
      end else begin
        @(negedge clk);
        bus.Start = 1;
        bus.Funct = (k == 6) ? 6'(32'h20 + $urandom_range(0, 3)) : fl[k];
        bus.OpA = a; bus.OpB = b;
        @(negedge clk);
        drive_idle();
      end
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
